// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and helpers for the device-side PS/2 transmitter.
//   - ps2_state_e    : transmitter FSM states
//   - PS2_FRAME_BITS : bits per frame (start, 8 data, parity, stop)
//   - ps2_frame()    : builds the 11-bit frame, bit 0 is sent first
//   - ps2_cnt_width(): width of the shared cycle counter
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    SETUP,
    LOW,
    RECOVER
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  // {stop=1, odd parity, data, start=0}; index 0 goes on the wire first.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // One counter serves both the half-period and the idle-detect timing,
  // so it must hold the larger of the two terminal counts.
  function automatic int ps2_cnt_width(input int clk_div, input int idle_cycles);
    int m;
    m = (clk_div > idle_cycles) ? clk_div : idle_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// ps2_device_tx_if: byte-stream handshake into the PS/2 transmitter.
//   tx_valid : source has a byte
//   tx_data  : byte to send
//   tx_ready : transmitter can accept a byte
// master = byte source, slave = transmitter.
interface ps2_device_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/ps2_sync.sv
// ps2_sync: two-flop synchronizer for an asynchronous PS/2 line.
//   clk, rst : system clock, synchronous active-high reset
//   i_async  : raw line level
//   o_sync   : synchronized level
// Resets to 1 so an idle (pulled-up) bus reads as idle straight out of reset.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: device-side PS/2 transmitter (keyboard/mouse emulation).
//   clk, rst     : system clock, synchronous active-high reset
//   tx_if        : byte handshake (slave side)
//   ps2_clk_i    : sensed PS2_CLK (asynchronous)
//   ps2_data_i   : sensed PS2_DATA (asynchronous)
//   ps2_clk_oe   : 1 pulls PS2_CLK low
//   ps2_data_oe  : 1 pulls PS2_DATA low
//   busy         : frame pending or in progress
//   done_o       : one-cycle pulse when a frame completes
//   abort_o      : one-cycle pulse when the host inhibits mid-frame
// Each bit is a SETUP half (clock released, data presented) followed by a
// LOW half (clock pulled low). An inhibit seen during SETUP aborts the frame
// and the held byte is resent once the bus has been idle again.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int IDLE_CYCLES = 16,
  parameter int INH_SKIP    = 3
) (
  input  logic            clk,
  input  logic            rst,
  ps2_device_tx_if.slave  tx_if,
  input  logic            ps2_clk_i,
  input  logic            ps2_data_i,
  output logic            ps2_clk_oe,
  output logic            ps2_data_oe,
  output logic            busy,
  output logic            done_o,
  output logic            abort_o
);

  localparam int             CW        = ps2_cnt_width(CLK_DIV, IDLE_CYCLES);
  localparam logic [CW-1:0]  DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0]  SKIP      = CW'(INH_SKIP);
  localparam logic [3:0]     LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  // Line synchronizers: index 0 = clock, index 1 = data.
  logic [1:0] w_line_raw;
  logic [1:0] w_line_sync;
  logic       w_clk_s;
  logic       w_data_s;

  assign w_line_raw = {ps2_data_i, ps2_clk_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    ps2_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (w_line_raw[gi]),
      .o_sync  (w_line_sync[gi])
    );
  end

  assign w_clk_s  = w_line_sync[0];
  assign w_data_s = w_line_sync[1];

  ps2_state_e                r_state;
  logic [CW-1:0]             r_cnt;
  logic [3:0]                r_bit;
  logic [7:0]                r_data;
  logic                      r_clk_oe;
  logic                      r_data_oe;
  logic                      r_done;
  logic                      r_abort;
  logic [PS2_FRAME_BITS-1:0] w_frame;
  logic                      w_accept;

  assign w_frame  = ps2_frame(r_data);
  assign w_accept = tx_if.tx_valid && tx_if.tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_data    <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= tx_if.tx_data;
            r_cnt   <= '0;
            r_state <= WAIT_IDLE;
          end
        end

        // Any low line (inhibit or request-to-send) restarts the idle count.
        WAIT_IDLE: begin
          if (w_clk_s && w_data_s) begin
            if (r_cnt == IDLE_LAST) begin
              r_state   <= SETUP;
              r_cnt     <= '0;
              r_bit     <= '0;
              r_data_oe <= ~w_frame[0];
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end

        // Early SETUP cycles still see our own LOW phase through the
        // synchronizer, so the inhibit check is masked there.
        SETUP: begin
          if ((r_cnt >= SKIP) && !w_clk_s) begin
            r_state   <= WAIT_IDLE;
            r_cnt     <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_abort   <= 1'b1;
          end else if (r_cnt == DIV_LAST) begin
            r_state  <= LOW;
            r_cnt    <= '0;
            r_clk_oe <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        LOW: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt    <= '0;
            r_clk_oe <= 1'b0;
            if (r_bit == LAST_BIT) begin
              r_state   <= RECOVER;
              r_data_oe <= 1'b0;
            end else begin
              r_state   <= SETUP;
              r_bit     <= r_bit + 4'd1;
              r_data_oe <= ~w_frame[r_bit + 4'd1];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        // Frame is committed; host inhibit is deliberately ignored here.
        RECOVER: begin
          if (r_cnt == DIV_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Gating with rst keeps every output quiet for the whole reset interval,
  // including the partial cycle before the first reset edge.
  assign tx_if.tx_ready = (r_state == IDLE) && !rst;
  assign busy           = (r_state != IDLE) && !rst;
  assign ps2_clk_oe     = r_clk_oe  && !rst;
  assign ps2_data_oe    = r_data_oe && !rst;
  assign done_o         = r_done    && !rst;
  assign abort_o        = r_abort   && !rst;

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: directed self-checking bench for ps2_device_tx.
// Bus model: each line is pulled up unless the DUT or the host pulls it low.
// The receiver samples PS2_DATA when ps2_clk_oe rises (falling PS/2 clock).
module tb_ps2_device_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic host_clk_pull  = 1'b0;
  logic host_data_pull = 1'b0;
  logic ps2_clk_oe, ps2_data_oe, busy, done_o, abort_o;
  logic line_clk, line_data;

  assign line_clk  = ~(ps2_clk_oe  | host_clk_pull);
  assign line_data = ~(ps2_data_oe | host_data_pull);

  ps2_device_tx_if tx_if ();

  ps2_device_tx #(
    .CLK_DIV     (8),
    .IDLE_CYCLES (16),
    .INH_SKIP    (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_if       (tx_if),
    .ps2_clk_i   (line_clk),
    .ps2_data_i  (line_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done_o      (done_o),
    .abort_o     (abort_o)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval after the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors
  int   mon_n = 0;
  logic mon_bit   [256];
  int   mon_fall  [256];
  int   mon_width [256];
  logic prev_oe = 1'b0;
  int   done_cnt = 0, done_cyc = 0, abort_cnt = 0;
  int   acc_n = 0;
  int   acc_cyc [16];

  always @(posedge clk) begin
    if (tx_if.tx_valid && tx_if.tx_ready && acc_n < 16) begin
      acc_cyc[acc_n] <= cyc;
      acc_n          <= acc_n + 1;
      $display("txn: byte %02h accepted in cycle %0d", tx_if.tx_data, cyc);
    end
  end

  always @(negedge clk) begin
    if (ps2_clk_oe && !prev_oe && mon_n < 256) begin
      mon_bit[mon_n]  <= line_data;
      mon_fall[mon_n] <= cyc;
      mon_n           <= mon_n + 1;
    end
    if (!ps2_clk_oe && prev_oe && mon_n > 0)
      mon_width[mon_n-1] <= cyc - mon_fall[mon_n-1];
    prev_oe <= ps2_clk_oe;
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      $display("txn: frame done in cycle %0d", cyc);
    end
    if (abort_o) begin
      abort_cnt <= abort_cnt + 1;
      $display("txn: frame aborted in cycle %0d", cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accept(input int base, output int acc);
    acc = -1;
    for (int k = 0; k < 400; k++) begin
      if (acc_n > base) break;
      tick();
    end
    if (acc_n > base) acc = acc_cyc[base];
    else chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int base);
    for (int k = 0; k < 600; k++) begin
      if (done_cnt > base) break;
      tick();
    end
    if (done_cnt <= base) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 400; k++) begin
      if (cyc >= target) break;
      tick();
    end
    if (cyc != target) chk("wait_cyc_timeout", cyc, target);
  endtask

  // Bits, falling-edge times, low widths and the reassembled byte.
  task automatic check_frame(input string tag, input int base, input logic [7:0] b,
                             input logic par, input int first_fall);
    logic [10:0] exp_bits;
    logic [7:0]  rx;
    exp_bits = {1'b1, par, b, 1'b0};
    rx = '0;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), mon_bit[base+i], exp_bits[i]);
      chk($sformatf("%s_fall%0d", tag, i), mon_fall[base+i], first_fall + 16*i);
      chk($sformatf("%s_width%0d", tag, i), mon_width[base+i], 32'd8);
    end
    for (int i = 0; i < 8; i++) rx[i] = mon_bit[base+1+i];
    chk($sformatf("%s_rx_byte", tag), rx, b);
  endtask

  // A held-low line before the handshake must delay the frame.
  task automatic held_line_test(input string tag, input logic [7:0] b, input logic par,
                                input logic use_clk);
    int nb, nd, a, r;
    nb = mon_n;
    nd = done_cnt;
    if (use_clk) host_clk_pull = 1'b1;
    else host_data_pull = 1'b1;
    repeat (3) tick();
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    wait_accept(acc_n, a);
    tx_if.tx_valid = 1'b0;
    repeat (40) tick();
    chk({tag, "_clk_oe_held"}, ps2_clk_oe, 1'b0);
    chk({tag, "_data_oe_held"}, ps2_data_oe, 1'b0);
    chk({tag, "_busy_held"}, busy, 1'b1);
    chk({tag, "_no_edges"}, mon_n - nb, 32'd0);
    host_clk_pull  = 1'b0;
    host_data_pull = 1'b0;
    r = cyc;
    wait_done(nd);
    check_frame(tag, nb, b, par, r + 26);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, nd, na, a, a1, a2, r;
    logic seen;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_tx_ready", tx_if.tx_ready, 1'b0);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_abort", abort_o, 1'b0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", tx_if.tx_ready, 1'b1);

    // 0x1C: bits 0,0,0,1,1,1,0,0,0 parity 0 stop 1
    nb = mon_n; nd = done_cnt;
    tx_if.tx_data  = 8'h1C;
    tx_if.tx_valid = 1'b1;
    wait_accept(acc_n, a);
    tx_if.tx_valid = 1'b0;
    chk("t1_busy", busy, 1'b1);
    wait_done(nd);
    chk("t1_done_cyc", done_cyc, a + 201);
    chk("t1_ready_at_done", tx_if.tx_ready, 1'b1);
    chk("t1_busy_at_done", busy, 1'b0);
    chk("t1_nbits", mon_n - nb, 32'd11);
    check_frame("t1", nb, 8'h1C, 1'b0, a + 25);

    // 0x00 then 0xFF back-to-back, valid held
    nb = mon_n; nd = done_cnt; na = abort_cnt;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b1;
    wait_accept(acc_n, a1);
    tx_if.tx_data = 8'hFF;
    wait_accept(acc_n, a2);
    tx_if.tx_valid = 1'b0;
    chk("t2_second_accept", a2, a1 + 201);
    chk("t2_accept_in_done", done_cyc, a2);
    wait_done(nd + 1);
    chk("t2_done_count", done_cnt - nd, 32'd2);
    chk("t2_no_abort", abort_cnt - na, 32'd0);
    check_frame("t2a", nb, 8'h00, 1'b1, a1 + 25);
    check_frame("t2b", nb + 11, 8'hFF, 1'b1, a2 + 25);

    // Inhibit during bit 5 SETUP, then full resend of the held byte
    nb = mon_n; nd = done_cnt; na = abort_cnt;
    tx_if.tx_data  = 8'hA5;
    tx_if.tx_valid = 1'b1;
    wait_accept(acc_n, a);
    tx_if.tx_valid = 1'b0;
    wait_cyc(a + 97);
    host_clk_pull = 1'b1;
    tx_if.tx_data = 8'h3C;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (abort_cnt > na) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t3_abort_seen", seen, 1'b1);
    chk("t3_clk_oe_released", ps2_clk_oe, 1'b0);
    chk("t3_data_oe_released", ps2_data_oe, 1'b0);
    chk("t3_busy", busy, 1'b1);
    repeat (195) tick();
    chk("t3_bits_before_abort", mon_n - nb, 32'd5);
    chk("t3_busy_inhibit", busy, 1'b1);
    host_clk_pull = 1'b0;
    r = cyc;
    wait_done(nd);
    chk("t3_abort_count", abort_cnt - na, 32'd1);
    check_frame("t3", nb + 5, 8'hA5, 1'b1, r + 26);

    // Clock inhibit, then request-to-send, before the handshake
    held_line_test("t4_inh", 8'h5A, 1'b1, 1'b1);
    held_line_test("t4_rts", 8'h81, 1'b1, 1'b0);

    // Inhibit during RECOVER is ignored
    nb = mon_n; nd = done_cnt; na = abort_cnt;
    tx_if.tx_data  = 8'h7E;
    tx_if.tx_valid = 1'b1;
    wait_accept(acc_n, a);
    tx_if.tx_valid = 1'b0;
    wait_cyc(a + 194);
    host_clk_pull = 1'b1;
    wait_done(nd);
    chk("t5_done_cyc", done_cyc, a + 201);
    chk("t5_no_abort", abort_cnt - na, 32'd0);
    check_frame("t5", nb, 8'h7E, 1'b1, a + 25);
    repeat (5) tick();
    host_clk_pull = 1'b0;
    repeat (5) tick();

    // Reset during bit 3 LOW
    nb = mon_n; nd = done_cnt; na = abort_cnt;
    tx_if.tx_data  = 8'h33;
    tx_if.tx_valid = 1'b1;
    wait_accept(acc_n, a);
    tx_if.tx_valid = 1'b0;
    wait_cyc(a + 75);
    chk("t6_clk_oe_in_low", ps2_clk_oe, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_clk_oe_rst", ps2_clk_oe, 1'b0);
    chk("t6_data_oe_rst", ps2_data_oe, 1'b0);
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_ready_rst", tx_if.tx_ready, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_ready_after_rst", tx_if.tx_ready, 1'b1);
    repeat (300) tick();
    chk("t6_no_done", done_cnt - nd, 32'd0);
    chk("t6_no_abort", abort_cnt - na, 32'd0);
    chk("t6_bits_sent", mon_n - nb, 32'd4);
    chk("t6_idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
